// File: rtl/zap_wb_walk_arbiter.sv
// Round-robin Wishbone B3 arbiter sharing one external memory port between the
// ZAP TLB walkers and cache line-fill FSMs. Define ZAP_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module zap_wb_walk_arbiter #(
  parameter int MASTERS = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic [MASTERS-1:0]      i_m_cyc_nxt,
  input  logic [MASTERS-1:0]      i_m_stb_nxt,
  input  logic [MASTERS-1:0]      i_m_wen_nxt,
  input  logic [4*MASTERS-1:0]    i_m_sel_nxt,
  input  logic [32*MASTERS-1:0]   i_m_adr_nxt,
  input  logic [32*MASTERS-1:0]   i_m_dat_nxt,
  output logic [MASTERS-1:0]      o_m_ack,
  output logic [31:0]             o_m_dat,
  output logic [MASTERS-1:0]      o_m_gnt,
  output logic                    o_wb_cyc,
  output logic                    o_wb_stb,
  output logic                    o_wb_wen,
  output logic [3:0]              o_wb_sel,
  output logic [31:0]             o_wb_adr,
  output logic [31:0]             o_wb_dat,
  input  logic [31:0]             i_wb_dat,
  input  logic                    i_wb_ack
);

  localparam int IW = $clog2(MASTERS);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t          state_r;
  logic [IW-1:0]   owner_r;
`ifndef ZAP_ARB_FIXED_PRIO_EN
  logic [IW-1:0]   ptr_r;
`endif

  logic [IW-1:0]   start_s;
  logic [IW-1:0]   idx_s;
  logic [IW-1:0]   win_s;
  logic            found_s;
  logic            hit_s;
  logic [IW-1:0]   src_s;
  logic            src_hit_s;
  logic            src_cyc_s;
  logic            src_stb_s;
  logic            src_wen_s;
  logic [3:0]      src_sel_s;
  logic [31:0]     src_adr_s;
  logic [31:0]     src_dat_s;

  // Index successor with explicit wrap so non-power-of-two MASTERS works.
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    logic [IW-1:0] r;
    if (v == IW'(MASTERS - 1)) begin
      r = {IW{1'b0}};
    end else begin
      r = v + IW'(1);
    end
    return r;
  endfunction

  function automatic logic [MASTERS-1:0] onehot(input logic [IW-1:0] v);
    logic [MASTERS-1:0] r;
    r = {MASTERS{1'b0}};
    for (int k = 0; k < MASTERS; k++) begin
      r[k] = (IW'(k) == v);
    end
    return r;
  endfunction

`ifdef ZAP_ARB_FIXED_PRIO_EN
  assign start_s = {IW{1'b0}};
`else
  assign start_s = ptr_r;
`endif

  // Winner search: first requester at or after start_s, wrapping modulo MASTERS.
  always_comb begin
    found_s = 1'b0;
    win_s   = start_s;
    idx_s   = start_s;
    hit_s   = 1'b0;
    for (int i = 0; i < MASTERS; i++) begin
      hit_s   = ~found_s & i_m_cyc_nxt[idx_s];
      win_s   = hit_s ? idx_s : win_s;
      found_s = found_s | hit_s;
      idx_s   = wrap_inc(idx_s);
    end
  end

  // Source mux: the current owner while OWNED, otherwise the prospective winner.
  always_comb begin
    src_s     = (state_r == OWNED) ? owner_r : win_s;
    src_hit_s = 1'b0;
    src_cyc_s = 1'b0;
    src_stb_s = 1'b0;
    src_wen_s = 1'b0;
    src_sel_s = 4'h0;
    src_adr_s = 32'h0;
    src_dat_s = 32'h0;
    for (int k = 0; k < MASTERS; k++) begin
      src_hit_s = (IW'(k) == src_s);
      src_cyc_s = src_cyc_s | (src_hit_s & i_m_cyc_nxt[k]);
      src_stb_s = src_stb_s | (src_hit_s & i_m_stb_nxt[k]);
      src_wen_s = src_wen_s | (src_hit_s & i_m_wen_nxt[k]);
      src_sel_s = src_sel_s | ({4{src_hit_s}} & i_m_sel_nxt[4*k +: 4]);
      src_adr_s = src_adr_s | ({32{src_hit_s}} & i_m_adr_nxt[32*k +: 32]);
      src_dat_s = src_dat_s | ({32{src_hit_s}} & i_m_dat_nxt[32*k +: 32]);
    end
  end

  // Arbitration FSM with registered grant and shared-port outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r  <= IDLE;
      owner_r  <= {IW{1'b0}};
`ifndef ZAP_ARB_FIXED_PRIO_EN
      ptr_r    <= {IW{1'b0}};
`endif
      o_m_gnt  <= {MASTERS{1'b0}};
      o_wb_cyc <= 1'b0;
      o_wb_stb <= 1'b0;
      o_wb_wen <= 1'b0;
      o_wb_sel <= 4'h0;
      o_wb_adr <= 32'h0;
      o_wb_dat <= 32'h0;
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            state_r  <= OWNED;
            owner_r  <= win_s;
            o_m_gnt  <= onehot(win_s);
            o_wb_cyc <= 1'b1;
            o_wb_stb <= src_stb_s;
            o_wb_wen <= src_wen_s;
            o_wb_sel <= src_sel_s;
            o_wb_adr <= src_adr_s;
            o_wb_dat <= src_dat_s;
          end else begin
            o_m_gnt  <= {MASTERS{1'b0}};
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_wb_wen <= 1'b0;
            o_wb_sel <= 4'h0;
            o_wb_adr <= 32'h0;
            o_wb_dat <= 32'h0;
          end
        end
        OWNED: begin
          if (src_cyc_s) begin
            o_wb_cyc <= 1'b1;
            o_wb_stb <= src_stb_s;
            o_wb_wen <= src_wen_s;
            o_wb_sel <= src_sel_s;
            o_wb_adr <= src_adr_s;
            o_wb_dat <= src_dat_s;
          end else begin
            // Release always wins over a same-cycle request; the next grant is decided in IDLE.
            state_r  <= IDLE;
`ifndef ZAP_ARB_FIXED_PRIO_EN
            ptr_r    <= wrap_inc(owner_r);
`endif
            o_m_gnt  <= {MASTERS{1'b0}};
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_wb_wen <= 1'b0;
            o_wb_sel <= 4'h0;
            o_wb_adr <= 32'h0;
            o_wb_dat <= 32'h0;
          end
        end
        default: begin
          state_r  <= IDLE;
          o_m_gnt  <= {MASTERS{1'b0}};
          o_wb_cyc <= 1'b0;
          o_wb_stb <= 1'b0;
          o_wb_wen <= 1'b0;
          o_wb_sel <= 4'h0;
          o_wb_adr <= 32'h0;
          o_wb_dat <= 32'h0;
        end
      endcase
    end
  end

  assign o_m_ack = {MASTERS{i_wb_ack}} & o_m_gnt;
  assign o_m_dat = i_wb_dat;

endmodule
